spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
Command/register-file stage that sits directly downstream of the SPI slave receive path and upstream of its transmit path. It parses received bytes as one-byte commands followed by an optional data byte, maintains a small bank of 8-bit control registers, and answers read commands by loading a byte into the SPI transmit path and handshaking on tx_start/tx_done. Its register bank drives the design's control outputs.

Parameters:
NREGS, 8, number of implemented 8-bit registers (1..16)
ADDR_W, 4, address field width taken from command bits [ADDR_W-1:0]; NREGS <= 2**ADDR_W
RESET_VAL, 8'h00, reset value of every register

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_valid  input  1  one-cycle pulse: rx_data holds a newly received byte
rx_data  input  8  received byte from SPI slave
frame_abort  input  1  chip-select deasserted; abort current transaction
tx_start  output  1  one-cycle pulse requesting SPI transmit of tx_data
tx_data  output  8  byte to transmit; stable from tx_start until tx_done
tx_done  input  1  one-cycle pulse: transmit complete
err_clr  input  1  clears sticky error flags
reg_flat  output  NREGS*8  register bank, reg i at bits [8i+7:8i]
wr_strobe  output  1  one-cycle pulse: a register was written
wr_addr  output  ADDR_W  address of last write
busy  output  1  high whenever state != IDLE
err_addr  output  1  sticky: out-of-range address accessed
err_overrun  output  1  sticky: byte received while awaiting tx_done

Behaviour:
- One clock, clk; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset: state IDLE, all registers = RESET_VAL, tx_start=0, tx_data=0, wr_strobe=0, wr_addr=0, busy=0, err_addr=0, err_overrun=0. Reset mid-transaction abandons it; no write commits and no tx_start is issued.
- Command byte: bit7 = 1 write, 0 read; bits [ADDR_W-1:0] = address; remaining bits ignored.
- FSM states: IDLE, WAIT_DATA, TX_WAIT.
- IDLE + rx_valid, write command: latch address, go to WAIT_DATA.
- IDLE + rx_valid, read command: next cycle tx_start=1 for exactly one cycle, tx_data = reg[addr] (8'h00 if addr >= NREGS); go to TX_WAIT.
- WAIT_DATA + rx_valid: if addr < NREGS, reg[addr] <= rx_data; wr_strobe=1 and wr_addr=addr in the following cycle (write-visible latency 1 cycle); return to IDLE. If addr >= NREGS, discard the byte, set err_addr, no wr_strobe, return to IDLE.
- Read with addr >= NREGS sets err_addr in the same cycle tx_start is issued.
- TX_WAIT + tx_done: go to IDLE; tx_data holds its value until overwritten by the next read.
- TX_WAIT + rx_valid (without abort): drop the byte, set err_overrun, remain in TX_WAIT.
- Same-cycle rx_valid and tx_done in TX_WAIT: byte dropped, err_overrun set, go to IDLE.
- frame_abort in any state: go to IDLE next cycle. Any pending write is discarded. If abort arrives in TX_WAIT, no further tx_start. frame_abort wins over a same-cycle rx_valid, which is dropped without error.
- tx_done outside TX_WAIT: ignored.
- err_clr: clears both sticky flags. A same-cycle set wins over clear.
- busy is combinational from state: high in WAIT_DATA and TX_WAIT.
- Back-to-back transactions: a command byte arriving the cycle after a return to IDLE is accepted with no dead cycles.

Test Plan:
- Reset, then write: rx 8'h83, rx 8'hA5 -> reg_flat[31:24]=8'hA5 one cycle after 2nd rx_valid; wr_strobe one pulse with wr_addr=3; other registers = 8'h00.
- Read-back: after the write above, rx 8'h03 -> tx_start single pulse next cycle, tx_data=8'hA5, busy=1 until tx_done pulse, then IDLE.
- Out of range (NREGS=8): rx 8'h8A, 8'h55 -> no register changes, no wr_strobe, err_addr=1. rx 8'h0C -> tx_data=8'h00, tx_start pulses. err_clr -> err_addr=0.
- Overrun: read reg 1, inject rx_valid 8'hFF before tx_done -> err_overrun=1, still TX_WAIT; tx_done -> IDLE; reg 1 unchanged.
- Abort: rx 8'h82, frame_abort, rx 8'h77 -> reg 2 unchanged, 8'h77 parsed as a read command of address 7 (tx_start pulses). frame_abort with same-cycle rx_valid -> byte dropped, no error flags set.
- Synchronous reset asserted while in WAIT_DATA -> next cycle state IDLE, all outputs at reset values, subsequent data byte treated as a command.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// Command parser and 8-bit register bank behind an SPI slave byte interface.
// Write = command byte (bit7=1) then data byte; read = command byte answered over tx_start/tx_done.
module spi_reg_bridge #(
    parameter int          NREGS     = 8,
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 frame_abort,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    input  logic                 err_clr,
    output logic [NREGS*8-1:0]   reg_flat,
    output logic                 wr_strobe,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 busy,
    output logic                 err_addr,
    output logic                 err_overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        TX_WAIT   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        reg_bank [NREGS];

    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        rd_val;
    logic              latch_addr;
    logic              issue_rd;
    logic              commit_wr;
    logic              set_err_addr;
    logic              set_err_overrun;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return int'(a) < NREGS;
    endfunction

    assign cmd_addr = rx_data[ADDR_W-1:0];
    assign busy     = (state != IDLE);

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign reg_flat[8*g +: 8] = reg_bank[g];
    end

    // Read mux: unimplemented addresses never match and return zero
    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (cmd_addr == ADDR_W'(i)) rd_val = reg_bank[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Decode: frame_abort dominates everything, including a same-cycle byte
    always_comb begin
        state_nxt       = state;
        latch_addr      = 1'b0;
        issue_rd        = 1'b0;
        commit_wr       = 1'b0;
        set_err_addr    = 1'b0;
        set_err_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && !frame_abort) begin
                    latch_addr = 1'b1;
                    if (rx_data[7]) begin
                        state_nxt = WAIT_DATA;
                    end else begin
                        state_nxt    = TX_WAIT;
                        issue_rd     = 1'b1;
                        set_err_addr = !addr_ok(cmd_addr);
                    end
                end
            end
            WAIT_DATA: begin
                if (frame_abort) begin
                    state_nxt = IDLE;
                end else if (rx_valid) begin
                    state_nxt = IDLE;
                    if (addr_ok(addr_q)) commit_wr    = 1'b1;
                    else                 set_err_addr = 1'b1;
                end
            end
            TX_WAIT: begin
                if (frame_abort) begin
                    state_nxt = IDLE;
                end else begin
                    if (rx_valid) set_err_overrun = 1'b1;
                    if (tx_done)  state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register stage: bank, transmit byte, strobes and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            err_addr    <= 1'b0;
            err_overrun <= 1'b0;
            for (int i = 0; i < NREGS; i++) reg_bank[i] <= RESET_VAL;
        end else begin
            tx_start    <= issue_rd;
            wr_strobe   <= commit_wr;
            err_addr    <= set_err_addr    | (err_addr    & ~err_clr);
            err_overrun <= set_err_overrun | (err_overrun & ~err_clr);
            if (issue_rd) tx_data <= rd_val;
            if (commit_wr) begin
                wr_addr <= addr_q;
                for (int i = 0; i < NREGS; i++) begin
                    if (addr_q == ADDR_W'(i)) reg_bank[i] <= rx_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latch_addr) addr_q <= cmd_addr;
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed, table-driven bench for spi_reg_bridge (NREGS=8, ADDR_W=4).
// Each table row is one clock: inputs driven before the edge, outputs checked just after it.
module tb_spi_reg_bridge;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        frame_abort;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        err_clr;
    logic [63:0] reg_flat;
    logic        wr_strobe;
    logic [3:0]  wr_addr;
    logic        busy;
    logic        err_addr;
    logic        err_overrun;

    int n_pass  = 0;
    int n_total = 0;

    spi_reg_bridge #(.NREGS(8), .ADDR_W(4), .RESET_VAL(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .frame_abort(frame_abort),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .err_clr    (err_clr),
        .reg_flat   (reg_flat),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .err_addr   (err_addr),
        .err_overrun(err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [7:0]  rd;
        logic        ab;
        logic        td;
        logic        ec;
        logic        e_start;
        logic [7:0]  e_txd;
        logic        e_wstb;
        logic [3:0]  e_waddr;
        logic        e_busy;
        logic        e_ea;
        logic        e_eo;
        logic [63:0] e_reg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rv, logic [7:0] rd, logic ab, logic td, logic ec,
                                logic es, logic [7:0] etxd, logic ew, logic [3:0] ewa,
                                logic eb, logic eea, logic eeo, logic [63:0] ereg);
        vec_t v;
        v.rv = rv; v.rd = rd; v.ab = ab; v.td = td; v.ec = ec;
        v.e_start = es; v.e_txd = etxd; v.e_wstb = ew; v.e_waddr = ewa;
        v.e_busy = eb; v.e_ea = eea; v.e_eo = eeo; v.e_reg = ereg;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        else             n_pass++;
    endtask

    task automatic check_all(input int idx, input logic es, input logic [7:0] etxd, input logic ew,
                             input logic [3:0] ewa, input logic eb, input logic eea, input logic eeo,
                             input logic [63:0] ereg);
        chk("tx_start",    idx, 64'(tx_start),    64'(es));
        chk("tx_data",     idx, 64'(tx_data),     64'(etxd));
        chk("wr_strobe",   idx, 64'(wr_strobe),   64'(ew));
        chk("wr_addr",     idx, 64'(wr_addr),     64'(ewa));
        chk("busy",        idx, 64'(busy),        64'(eb));
        chk("err_addr",    idx, 64'(err_addr),    64'(eea));
        chk("err_overrun", idx, 64'(err_overrun), 64'(eeo));
        chk("reg_flat",    idx, reg_flat,         ereg);
    endtask

    task automatic step(input logic rv, input logic [7:0] rd, input logic ab, input logic td,
                        input logic ec, input logic rs);
        @(negedge clk);
        rx_valid = rv; rx_data = rd; frame_abort = ab; tx_done = td; err_clr = ec; reset = rs;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; frame_abort = 1'b0; tx_done = 1'b0; err_clr = 1'b0; reset = 1'b0;
    endtask

    localparam logic [63:0] R0 = 64'h0000_0000_0000_0000;
    localparam logic [63:0] R1 = 64'h0000_0000_A500_0000;
    localparam logic [63:0] R2 = 64'h0000_0000_A500_3C00;

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_abort = 1'b0;
        tx_done = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all(0, 0, 8'h00, 0, 4'd0, 0, 0, 0, R0);

        //             rv rd     ab td ec   st txd    ws wa    bsy ea eo reg
        vecs.push_back(mk(1, 8'h83, 0, 0, 0,  0, 8'h00, 0, 4'd0, 1, 0, 0, R0));
        vecs.push_back(mk(1, 8'hA5, 0, 0, 0,  0, 8'h00, 1, 4'd3, 0, 0, 0, R1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 4'd3, 0, 0, 0, R1));
        vecs.push_back(mk(1, 8'h03, 0, 0, 0,  1, 8'hA5, 0, 4'd3, 1, 0, 0, R1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0,  0, 8'hA5, 0, 4'd3, 1, 0, 0, R1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 8'hA5, 0, 4'd3, 0, 0, 0, R1));
        vecs.push_back(mk(1, 8'h8A, 0, 0, 0,  0, 8'hA5, 0, 4'd3, 1, 0, 0, R1));
        vecs.push_back(mk(1, 8'h55, 0, 0, 0,  0, 8'hA5, 0, 4'd3, 0, 1, 0, R1));
        vecs.push_back(mk(1, 8'h0C, 0, 0, 0,  1, 8'h00, 0, 4'd3, 1, 1, 0, R1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1,  0, 8'h00, 0, 4'd3, 0, 0, 0, R1));
        vecs.push_back(mk(1, 8'h81, 0, 0, 0,  0, 8'h00, 0, 4'd3, 1, 0, 0, R1));
        vecs.push_back(mk(1, 8'h3C, 0, 0, 0,  0, 8'h00, 1, 4'd1, 0, 0, 0, R2));
        vecs.push_back(mk(1, 8'h01, 0, 0, 0,  1, 8'h3C, 0, 4'd1, 1, 0, 0, R2));
        vecs.push_back(mk(1, 8'hFF, 0, 0, 0,  0, 8'h3C, 0, 4'd1, 1, 0, 1, R2));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 8'h3C, 0, 4'd1, 0, 0, 1, R2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'h3C, 0, 4'd1, 0, 0, 0, R2));
        vecs.push_back(mk(1, 8'h03, 0, 0, 0,  1, 8'hA5, 0, 4'd1, 1, 0, 0, R2));
        vecs.push_back(mk(1, 8'h44, 0, 1, 0,  0, 8'hA5, 0, 4'd1, 0, 0, 1, R2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'hA5, 0, 4'd1, 0, 0, 0, R2));
        vecs.push_back(mk(1, 8'h82, 0, 0, 0,  0, 8'hA5, 0, 4'd1, 1, 0, 0, R2));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0,  0, 8'hA5, 0, 4'd1, 0, 0, 0, R2));
        vecs.push_back(mk(1, 8'h77, 0, 0, 0,  1, 8'h00, 0, 4'd1, 1, 0, 0, R2));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 8'h00, 0, 4'd1, 0, 0, 0, R2));
        vecs.push_back(mk(1, 8'h85, 1, 0, 0,  0, 8'h00, 0, 4'd1, 0, 0, 0, R2));
        vecs.push_back(mk(1, 8'h82, 0, 0, 0,  0, 8'h00, 0, 4'd1, 1, 0, 0, R2));
        vecs.push_back(mk(1, 8'h99, 1, 0, 0,  0, 8'h00, 0, 4'd1, 0, 0, 0, R2));
        vecs.push_back(mk(1, 8'h03, 0, 0, 0,  1, 8'hA5, 0, 4'd1, 1, 0, 0, R2));
        vecs.push_back(mk(1, 8'h11, 1, 0, 0,  0, 8'hA5, 0, 4'd1, 0, 0, 0, R2));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 8'hA5, 0, 4'd1, 0, 0, 0, R2));
        vecs.push_back(mk(1, 8'h8F, 0, 0, 0,  0, 8'hA5, 0, 4'd1, 1, 0, 0, R2));
        vecs.push_back(mk(1, 8'h12, 0, 0, 1,  0, 8'hA5, 0, 4'd1, 0, 1, 0, R2));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 8'hA5, 0, 4'd1, 0, 0, 0, R2));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rv, vecs[i].rd, vecs[i].ab, vecs[i].td, vecs[i].ec, 1'b0);
            check_all(i + 1, vecs[i].e_start, vecs[i].e_txd, vecs[i].e_wstb, vecs[i].e_waddr,
                      vecs[i].e_busy, vecs[i].e_ea, vecs[i].e_eo, vecs[i].e_reg);
        end

        // Reset while a write is pending, with a sticky error set beforehand
        step(1, 8'h8F, 0, 0, 0, 0);
        step(1, 8'h12, 0, 0, 0, 0);
        chk("err_addr_set", 100, 64'(err_addr), 64'd1);
        step(1, 8'h84, 0, 0, 0, 0);
        chk("busy_wait_data", 101, 64'(busy), 64'd1);
        step(0, 8'h00, 0, 0, 0, 1);
        check_all(102, 0, 8'h00, 0, 4'd0, 0, 0, 0, R0);
        // Byte after reset is a read command of reg 3, not data for reg 4
        step(1, 8'h03, 0, 0, 0, 0);
        check_all(103, 1, 8'h00, 0, 4'd0, 1, 0, 0, R0);
        step(0, 8'h00, 0, 1, 0, 0);
        check_all(104, 0, 8'h00, 0, 4'd0, 0, 0, 0, R0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
